z80_bus_initiator: RTL and testbench
====================================

Z80_BUS_INITIATOR -- requirements
Module: z80_bus_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, Z80 address bus width.
REQ-002 SHALL have parameter WAIT_LIMIT, default 255, the maximum number of WAITn-extended cycles before a cycle is aborted.
REQ-003 SHALL have port clk, input, 1, the single clock; one clk period is one Z80 T-state.
REQ-004 SHALL have port RESETn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1, transaction request.
REQ-006 SHALL have port req_ready, output, 1, request accepted when req_valid and req_ready are both high at a clk edge.
REQ-007 SHALL have port req_type, input, 3, transaction type: 0 mem read, 1 mem write, 2 io read, 3 io write, 4 refresh; other codes reserved.
REQ-008 SHALL have port req_addr, input, ADDR_WIDTH, transaction address.
REQ-009 SHALL have port req_wdata, input, 8, write data.
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 8, read data.
REQ-012 SHALL have port rsp_err, output, 1, wait-timeout flag, qualified by rsp_valid.
REQ-013 SHALL have port A, output, ADDR_WIDTH, bus address.
REQ-014 SHALL have port D, inout, 8, bus data, tri-stated when not driven.
REQ-015 SHALL have ports MREQn, IORQn, RDn, WRn, RFSHn, each output, 1, active-low bus strobes.
REQ-016 SHALL have port WAITn, input, 1, active-low wait from the responder.

Function
REQ-017 SHALL implement states IDLE, T1, T2, TW, T3, RF; all outputs SHALL be registered.
REQ-018 req_ready SHALL be high only in IDLE; acceptance moves to T1 on the same edge and latches type, addr and wdata.
REQ-019 Mem read SHALL follow T1 -> T2 -> T3 -> IDLE, with MREQn=0 and RDn=0 from T1 through T3.
REQ-020 Mem write SHALL drive D from T1 through T3, with MREQn=0 from T1 through T3 and WRn=0 in T2 and T3 only.
REQ-021 IO cycles SHALL follow T1 -> T2 -> TW -> T3 -> IDLE, with IORQn and RDn/WRn low from T2 through T3; io write SHALL drive D from T1 through T3.
REQ-022 Refresh SHALL follow RF for 2 cycles -> IDLE, with MREQn=0 and RFSHn=0 in both cycles, RDn=WRn=1, and A = latched addr.
REQ-023 WAITn SHALL be sampled in T2 for mem cycles and in TW for io cycles; while low, the state SHALL repeat and the wait counter SHALL increment.
REQ-024 If the wait counter reaches WAIT_LIMIT, the block SHALL go to IDLE with strobes deasserted, rsp_valid=1 and rsp_err=1.
REQ-025 Reads SHALL capture D into rsp_rdata at the edge leaving T3; rsp_rdata SHALL hold until the next read completes.
REQ-026 rsp_valid SHALL pulse for one cycle on the first IDLE cycle after every transaction (all types); rsp_err SHALL be 0 except on a timeout.
REQ-027 Nominal latency from the accept edge to rsp_valid SHALL be 3 cycles for mem, 4 for io and 2 for refresh, plus wait cycles.
REQ-028 Back-to-back requests SHALL be accepted in the rsp_valid IDLE cycle, giving no idle gap.
REQ-029 A reserved req_type SHALL be accepted and completed as a 1-cycle no-op with rsp_err=1 and no strobes asserted.
REQ-030 In IDLE, A SHALL hold the last address, all strobes SHALL be 1 and D SHALL be high-Z.
REQ-031 The wait counter SHALL be 8 bits wide or more, saturating, and cleared on every accept.

Reset
REQ-032 While RESETn=0, the block SHALL immediately (asynchronously) enter IDLE with all strobes=1, D high-Z, A=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, wait counter=0.
REQ-033 req_ready SHALL be 0 while RESETn=0 and SHALL be 1 on the first edge after release.
REQ-034 Reset asserted mid-cycle SHALL abort the cycle with no rsp_valid.

Verification
REQ-035 Mem read, addr 0x6000, responder drives D=0xA5, WAITn=1 -> MREQn/RDn low for 3 cycles, rsp_valid 3 cycles after accept, rsp_rdata=0xA5.
REQ-036 Io write, addr 0x00FF, wdata 0x3C -> IORQn/WRn low for 3 cycles starting at T2, D=0x3C from T1 through T3, rsp_valid after 4 cycles.
REQ-037 Mem read with WAITn low for 5 cycles -> T2 repeated 5 times, rsp_valid after 8 cycles, rsp_err=0.
REQ-038 WAITn held low with WAIT_LIMIT=4 -> abort after 4 wait cycles, rsp_valid=1, rsp_err=1, strobes high.
REQ-039 Refresh, addr 0x0012 -> MREQn=RFSHn=0 for 2 cycles, RDn=WRn=1, A=0x0012.
REQ-040 RESETn pulled low during T2 of a mem write -> strobes high and D high-Z immediately, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/z80_bus_initiator_if.sv
// Request/response handshake plus Z80 address and strobe lines of z80_bus_initiator.
// D stays a plain inout port on the initiator so the shared tri-state net remains a simple wire.
interface z80_bus_initiator_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_type;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [7:0]            req_wdata;
  logic                  rsp_valid;
  logic [7:0]            rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] A;
  logic                  MREQn;
  logic                  IORQn;
  logic                  RDn;
  logic                  WRn;
  logic                  RFSHn;
  logic                  WAITn;

  modport master (
    input  req_valid, req_type, req_addr, req_wdata, WAITn,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, A, MREQn, IORQn, RDn, WRn, RFSHn
  );

  modport slave (
    output req_valid, req_type, req_addr, req_wdata, WAITn,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, A, MREQn, IORQn, RDn, WRn, RFSHn
  );
endinterface

// File: rtl/z80_bus_initiator.sv
// Z80 bus-cycle initiator: 3/4/2 T-states (mem/io/refresh) plus WAITn cycles, with a timeout abort.
// Accepts only in IDLE (req_ready); rsp_valid pulses on the first IDLE cycle, where the next request may be taken.
module z80_bus_initiator #(
  parameter int ADDR_WIDTH = 16,
  parameter int WAIT_LIMIT = 255
) (
  input  logic                clk,
  input  logic                RESETn,
  z80_bus_initiator_if.master bus,
  inout  wire  [7:0]          D
);
  localparam int CW = (WAIT_LIMIT > 255) ? $clog2(WAIT_LIMIT + 1) : 8;
  localparam logic [2:0] MEM_RD  = 3'd0;
  localparam logic [2:0] MEM_WR  = 3'd1;
  localparam logic [2:0] IO_RD   = 3'd2;
  localparam logic [2:0] IO_WR   = 3'd3;
  localparam logic [2:0] REFRESH = 3'd4;

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, RF} state_t;

  state_t                state_q, state_d;
  logic [2:0]            typ_q, typ_d;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [7:0]            wdata_q, rdata_q;
  logic [CW-1:0]         wait_cnt_q;
  logic                  rf_q, noop_q;
  logic                  ready_q, rsp_valid_q, rsp_err_q, d_oe_q;
  logic                  mreqn_q, iorqn_q, rdn_q, wrn_q, rfshn_q;
  logic                  accept, wait_hit, wait_inc, timeout, noop_start;
  logic                  is_io, is_rd, is_wr;
  logic                  ready_d, rsp_valid_d, rsp_err_d, d_oe_d;
  logic                  mreqn_d, iorqn_d, rdn_d, wrn_d, rfshn_d;

  always_comb begin
    state_d    = state_q;
    typ_d      = typ_q;
    wait_inc   = 1'b0;
    timeout    = 1'b0;
    noop_start = 1'b0;
    accept     = bus.req_valid && ready_q;
    wait_hit   = (int'(wait_cnt_q) + 1 >= WAIT_LIMIT);
    case (state_q)
      IDLE: if (accept) begin
        typ_d = bus.req_type;
        if (bus.req_type == REFRESH)    state_d = RF;
        else if (bus.req_type <= IO_WR) state_d = T1;
        else                            noop_start = 1'b1;
      end
      T1: state_d = T2;
      // Memory cycles sample WAITn in T2; IO cycles always pass through TW and sample there.
      T2: begin
        if (typ_q == IO_RD || typ_q == IO_WR) begin
          state_d = TW;
        end else if (!bus.WAITn) begin
          wait_inc = 1'b1;
          if (wait_hit) begin
            timeout = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = T3;
        end
      end
      TW: begin
        if (!bus.WAITn) begin
          wait_inc = 1'b1;
          if (wait_hit) begin
            timeout = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = T3;
        end
      end
      T3: state_d = IDLE;
      RF: if (rf_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so that every bus output comes straight from a flop.
    is_io   = (typ_d == IO_RD) || (typ_d == IO_WR);
    is_rd   = (typ_d == MEM_RD) || (typ_d == IO_RD);
    is_wr   = (typ_d == MEM_WR) || (typ_d == IO_WR);
    mreqn_d = 1'b1;
    iorqn_d = 1'b1;
    rdn_d   = 1'b1;
    wrn_d   = 1'b1;
    rfshn_d = 1'b1;
    d_oe_d  = 1'b0;
    case (state_d)
      T1: begin
        mreqn_d = is_io;
        rdn_d   = !(is_rd && !is_io);
        d_oe_d  = is_wr;
      end
      T2, TW, T3: begin
        mreqn_d = is_io;
        iorqn_d = !is_io;
        rdn_d   = !is_rd;
        wrn_d   = !is_wr;
        d_oe_d  = is_wr;
      end
      RF: begin
        mreqn_d = 1'b0;
        rfshn_d = 1'b0;
      end
      default: ;
    endcase

    ready_d     = (state_d == IDLE) && !noop_start;
    rsp_valid_d = ((state_q != IDLE) && (state_d == IDLE)) || noop_q;
    rsp_err_d   = timeout || noop_q;
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= IDLE;
      typ_q       <= MEM_RD;
      a_q         <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wait_cnt_q  <= '0;
      rf_q        <= 1'b0;
      noop_q      <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      d_oe_q      <= 1'b0;
      mreqn_q     <= 1'b1;
      iorqn_q     <= 1'b1;
      rdn_q       <= 1'b1;
      wrn_q       <= 1'b1;
      rfshn_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      typ_q       <= typ_d;
      rf_q        <= (state_q == RF) && !rf_q;
      noop_q      <= noop_start;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      d_oe_q      <= d_oe_d;
      mreqn_q     <= mreqn_d;
      iorqn_q     <= iorqn_d;
      rdn_q       <= rdn_d;
      wrn_q       <= wrn_d;
      rfshn_q     <= rfshn_d;
      if (accept) begin
        a_q        <= bus.req_addr;
        wdata_q    <= bus.req_wdata;
        wait_cnt_q <= '0;
      end else if (wait_inc && !(&wait_cnt_q)) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (state_q == T3 && (typ_q == MEM_RD || typ_q == IO_RD)) rdata_q <= D;
    end
  end

  assign D             = d_oe_q ? wdata_q : 8'bz;
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.A         = a_q;
  assign bus.MREQn     = mreqn_q;
  assign bus.IORQn     = iorqn_q;
  assign bus.RDn       = rdn_q;
  assign bus.WRn       = wrn_q;
  assign bus.RFSHn     = rfshn_q;
endmodule

// File: tb/tb_z80_bus_initiator.sv
// Bench for z80_bus_initiator: directed and random transactions scored against a cycle-count model,
// plus a WAIT_LIMIT=4 instance for the timeout abort.
module tb_z80_bus_initiator;
  localparam int WL = 255;

  logic       clk = 1'b0;
  logic       RESETn;
  logic [7:0] rsp_byte;
  logic [7:0] exp_rdata;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  z80_bus_initiator_if #(.ADDR_WIDTH(16)) bus ();
  z80_bus_initiator_if #(.ADDR_WIDTH(16)) bus4 ();
  wire [7:0] D;
  wire [7:0] D4;

  // Responder returns rsp_byte whenever the initiator strobes RDn.
  assign D  = !bus.RDn  ? rsp_byte : 8'bz;
  assign D4 = !bus4.RDn ? 8'h77    : 8'bz;

  z80_bus_initiator #(.ADDR_WIDTH(16), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .RESETn(RESETn), .bus(bus), .D(D));
  z80_bus_initiator #(.ADDR_WIDTH(16), .WAIT_LIMIT(4)) dut4 (
    .clk(clk), .RESETn(RESETn), .bus(bus4), .D(D4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [4:0] strobes();
    return {bus.MREQn, bus.IORQn, bus.RDn, bus.WRn, bus.RFSHn};
  endfunction

  // Entered on a negedge with the initiator idle; returns on the negedge showing rsp_valid.
  task automatic run_txn(input logic [2:0] typ, input logic [15:0] addr, input logic [7:0] wd,
                         input int w, input logic [7:0] rb);
    string nm[5] = '{"rfsh", "wr", "rd", "iorq", "mreq"};
    int    ecnt[5], efirst[5], cnt[5], first[5];
    int    lat, low, k, a_bad, d_ok;
    bit    ismem, isio, rd, wr, rsv, to, done;
    logic [4:0] s;

    ismem = (typ <= 3'd1);
    isio  = (typ == 3'd2) || (typ == 3'd3);
    rsv   = (typ > 3'd4);
    rd    = (typ == 3'd0) || (typ == 3'd2);
    wr    = (typ == 3'd1) || (typ == 3'd3);
    to    = (ismem || isio) && (w >= WL);
    for (int i = 0; i < 5; i++) begin
      ecnt[i] = 0; efirst[i] = -1; cnt[i] = 0; first[i] = -1;
    end
    lat = 1;
    low = 0;
    if (ismem) begin
      lat = to ? 1 + WL : 3 + w;
      low = w + 1;
      ecnt[4] = lat; efirst[4] = 0;
      if (rd) begin ecnt[2] = lat;     efirst[2] = 0; end
      if (wr) begin ecnt[1] = lat - 1; efirst[1] = 1; end
    end else if (isio) begin
      lat = to ? 2 + WL : 4 + w;
      low = w + 2;
      ecnt[3] = lat - 1; efirst[3] = 1;
      if (rd) begin ecnt[2] = lat - 1; efirst[2] = 1; end
      if (wr) begin ecnt[1] = lat - 1; efirst[1] = 1; end
    end else if (typ == 3'd4) begin
      lat = 2;
      ecnt[4] = 2; efirst[4] = 0;
      ecnt[0] = 2; efirst[0] = 0;
    end
    if (rd && !to) exp_rdata = rb;

    rsp_byte = rb;
    check("ready_before_req", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_type  = typ;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    k = 0; done = 0; a_bad = 0; d_ok = 0;
    while (!done && k < 600) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.rsp_valid) begin
        done = 1;
      end else begin
        s = strobes();
        for (int i = 0; i < 5; i++) begin
          if (!s[i]) begin
            cnt[i]++;
            if (first[i] < 0) first[i] = k;
          end
        end
        if (bus.A !== addr) a_bad++;
        if (D === wd) d_ok++;
        bus.WAITn = !(k < low);
        k++;
      end
    end
    bus.WAITn = 1'b1;
    check($sformatf("latency_t%0d_w%0d", typ, w), done ? k : 9999, lat);
    check("rsp_err", 32'(bus.rsp_err), (to || rsv) ? 32'd1 : 32'd0);
    check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
    check("strobes_idle", 32'(strobes()), 32'h1F);
    check("addr_held", 32'(bus.A), 32'(addr));
    check("addr_during", a_bad, 0);
    if (wr) check("d_driven", d_ok, lat);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s_cnt", nm[i]), cnt[i], ecnt[i]);
      check($sformatf("%s_first", nm[i]), first[i], efirst[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k4, m4, seen;
    logic [2:0] typ;

    RESETn = 1'b1;
    bus.req_valid = 1'b0;  bus.req_type = 3'd0;  bus.req_addr = '0;  bus.req_wdata = '0;  bus.WAITn = 1'b1;
    bus4.req_valid = 1'b0; bus4.req_type = 3'd0; bus4.req_addr = '0; bus4.req_wdata = '0; bus4.WAITn = 1'b1;
    rsp_byte = 8'h00;
    exp_rdata = 8'h00;
    #1 RESETn = 1'b0;
    #3;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_strobes", 32'(strobes()), 32'h1F);
    check("rst_addr", 32'(bus.A), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    repeat (3) @(negedge clk);
    RESETn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_release", 32'(bus.req_ready), 32'd1);

    run_txn(3'd0, 16'h6000, 8'h11, 0, 8'hA5);      // mem read, no waits
    run_txn(3'd3, 16'h00FF, 8'h3C, 0, 8'h00);      // io write
    run_txn(3'd0, 16'h6001, 8'h22, 5, 8'h5B);      // mem read, 5 wait cycles
    run_txn(3'd4, 16'h0012, 8'h33, 0, 8'h00);      // refresh
    run_txn(3'd6, 16'h0BAD, 8'h44, 0, 8'h00);      // reserved type
    run_txn(3'd2, 16'h0040, 8'h55, 2, 8'hC3);      // io read with extra waits
    run_txn(3'd1, 16'h8000, 8'h66, 1000, 8'h00);   // mem write held in WAITn until timeout

    for (int n = 0; n < 40; n++) begin
      typ = 3'($urandom_range(0, 5));
      if (typ == 3'd5) typ = 3'($urandom_range(5, 7));
      run_txn(typ, 16'($urandom), 8'($urandom_range(1, 255)), int'($urandom_range(0, 6)), 8'($urandom));
    end

    // Timeout on the WAIT_LIMIT=4 instance: T1 plus four stalled T2 cycles, then abort.
    bus4.req_valid = 1'b1; bus4.req_type = 3'd0; bus4.req_addr = 16'h1234; bus4.WAITn = 1'b0;
    @(posedge clk);
    k4 = 0; m4 = 0;
    while (k4 < 50) begin
      @(negedge clk);
      bus4.req_valid = 1'b0;
      if (bus4.rsp_valid) break;
      if (!bus4.MREQn) m4++;
      k4++;
    end
    check("lim4_latency", k4, 5);
    check("lim4_mreq_cnt", m4, 5);
    check("lim4_rsp_err", 32'(bus4.rsp_err), 32'd1);
    check("lim4_strobes", 32'({bus4.MREQn, bus4.IORQn, bus4.RDn, bus4.WRn, bus4.RFSHn}), 32'h1F);
    check("lim4_rdata", 32'(bus4.rsp_rdata), 32'd0);
    bus4.WAITn = 1'b1;

    // Reset during T2 of a mem write.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_type = 3'd1; bus.req_addr = 16'h4444; bus.req_wdata = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("midrst_wr_low", 32'(bus.WRn), 32'd0);
    RESETn = 1'b0;
    #1;
    check("midrst_strobes", 32'(strobes()), 32'h1F);
    check("midrst_d_released", 32'(D === 8'h5A), 32'd0);
    check("midrst_ready", 32'(bus.req_ready), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_addr", 32'(bus.A), 32'd0);
    check("midrst_rdata", 32'(bus.rsp_rdata), 32'd0);
    @(negedge clk);
    RESETn = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("midrst_no_rsp", seen, 0);
    check("midrst_ready_after", 32'(bus.req_ready), 32'd1);
    exp_rdata = 8'h00;
    run_txn(3'd0, 16'h2222, 8'h01, 1, 8'h9E);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
